hex_entry_ctrl: RTL and testbench

Input-side counterpart to the processor's 7-segment output path. Lets an operator enter a 32-bit word on the board one hex digit at a time using 4 slide switches and push buttons, then hands the word to the datapath through a valid/ready handshake. Buttons are synchronised and debounced internally. The word being edited is exported so it can drive the existing eight-digit display.

---
 rtl/hex_entry_ctrl.sv | 134 +++++++++++++
 tb/tb_hex_entry_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_entry_ctrl.sv
// Hex keypad-style word entry: debounced buttons build a 32-bit word digit by digit,
// then hand it off via valid/ready. Optional backspace button: define ENTRY_BACKSPACE_EN.
`timescale 1ns/1ps

module hex_entry_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic press_o
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] count;

    // Level is only accepted after an unbroken run of disagreeing samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            count   <= '0;
        end else begin
            sync1   <= raw_i;
            sync2   <= sync1;
            level_d <= level;
            if (sync2 != level) begin
                if (count == LAST) begin
                    level <= sync2;
                    count <= '0;
                end else begin
                    count <= count + CW'(1);
                end
            end else begin
                count <= '0;
            end
        end
    end

    assign press_o = level & ~level_d;
endmodule

module hex_entry_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned DIGITS          = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  nibble_i,
    input  logic        btn_load_i,
    input  logic        btn_commit_i,
    input  logic        btn_clear_i,
`ifdef ENTRY_BACKSPACE_EN
    input  logic        btn_back_i,
`endif
    input  logic        ready_i,
    output logic [31:0] edit_o,
    output logic [3:0]  digit_cnt_o,
    output logic        full_o,
    output logic [31:0] data_o,
    output logic        valid_o
);
    localparam logic [3:0]  DIGIT_MAX = 4'(DIGITS);
    localparam logic [31:0] EDIT_MASK = 32'hFFFF_FFFF >> (32 - 4 * DIGITS);

    typedef enum logic {EDIT, HOLD} state_t;

    state_t state;
    logic   load_p;
    logic   commit_p;
    logic   clear_p;
    logic   back_p;

    hex_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk_i(clk_i), .rst_i(rst_i), .raw_i(btn_load_i), .press_o(load_p));
    hex_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_commit (
        .clk_i(clk_i), .rst_i(rst_i), .raw_i(btn_commit_i), .press_o(commit_p));
    hex_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk_i(clk_i), .rst_i(rst_i), .raw_i(btn_clear_i), .press_o(clear_p));
`ifdef ENTRY_BACKSPACE_EN
    hex_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_back (
        .clk_i(clk_i), .rst_i(rst_i), .raw_i(btn_back_i), .press_o(back_p));
`else
    assign back_p = 1'b0;
`endif

    // Only one action per cycle: clear beats commit beats backspace beats load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= EDIT;
            edit_o      <= '0;
            digit_cnt_o <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
        end else begin
            case (state)
                EDIT: begin
                    if (clear_p) begin
                        edit_o      <= '0;
                        digit_cnt_o <= '0;
                    end else if (commit_p && digit_cnt_o != 4'd0) begin
                        data_o      <= edit_o;
                        valid_o     <= 1'b1;
                        edit_o      <= '0;
                        digit_cnt_o <= '0;
                        state       <= HOLD;
                    end else if (back_p && digit_cnt_o != 4'd0) begin
                        edit_o      <= edit_o >> 4;
                        digit_cnt_o <= digit_cnt_o - 4'd1;
                    end else if (load_p && digit_cnt_o < DIGIT_MAX) begin
                        edit_o      <= {edit_o[27:0], nibble_i} & EDIT_MASK;
                        digit_cnt_o <= digit_cnt_o + 4'd1;
                    end
                end
                HOLD: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        state   <= EDIT;
                    end
                end
                default: state <= EDIT;
            endcase
        end
    end

    assign full_o = (digit_cnt_o == DIGIT_MAX);
endmodule

// File: tb/tb_hex_entry_ctrl.sv
// Bench for hex_entry_ctrl: directed scenarios plus random button traffic, all outputs
// checked every cycle against a digit-queue model. Honours ENTRY_BACKSPACE_EN.
`timescale 1ns/1ps

module tb_hex_entry_ctrl;
    localparam int D      = 4;
    localparam int DIGITS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  nibble = 4'd0;
    logic        btn_load = 1'b0;
    logic        btn_commit = 1'b0;
    logic        btn_clear = 1'b0;
    logic        btn_back = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] edit;
    logic [3:0]  digit_cnt;
    logic        full;
    logic [31:0] data;
    logic        valid;

    int n_compared = 0;
    int n_mismatched = 0;
    int valid_cycles = 0;
    bit started = 0;

    hex_entry_ctrl #(.DEBOUNCE_CYCLES(D), .DIGITS(DIGITS)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .nibble_i(nibble),
        .btn_load_i(btn_load),
        .btn_commit_i(btn_commit),
        .btn_clear_i(btn_clear),
`ifdef ENTRY_BACKSPACE_EN
        .btn_back_i(btn_back),
`endif
        .ready_i(ready),
        .edit_o(edit),
        .digit_cnt_o(digit_cnt),
        .full_o(full),
        .data_o(data),
        .valid_o(valid)
    );

    always #5 clk = ~clk;

    // Reference model: entered digits kept as a queue, debouncer as sample history.
    int          m_digits[$];
    logic [31:0] m_data;
    bit          m_valid;
    bit          hist0[4], hist1[4], acc[4], pend[4];
    int          run[4];

    function automatic logic [31:0] word_of(input int q[$]);
        logic [31:0] w = 32'd0;
        foreach (q[i]) w = (w << 4) | 32'(q[i]);
        return w;
    endfunction

    always @(posedge clk) begin
        bit raw[4];
        bit p[4];
        bit cmp;
        started = 1;
        raw[0] = btn_load; raw[1] = btn_commit; raw[2] = btn_clear; raw[3] = btn_back;
        if (rst) begin
            m_digits.delete();
            m_data  = 32'd0;
            m_valid = 0;
            for (int b = 0; b < 4; b++) begin
                hist0[b] = 0; hist1[b] = 0; acc[b] = 0; pend[b] = 0; run[b] = 0;
            end
        end else begin
            p = pend;
`ifndef ENTRY_BACKSPACE_EN
            p[3] = 0;
`endif
            if (m_valid) begin
                if (ready) m_valid = 0;
            end else if (p[2]) begin
                m_digits.delete();
            end else if (p[1] && m_digits.size() > 0) begin
                m_data  = word_of(m_digits);
                m_valid = 1;
                m_digits.delete();
            end else if (p[3] && m_digits.size() > 0) begin
                void'(m_digits.pop_back());
            end else if (p[0] && m_digits.size() < DIGITS) begin
                m_digits.push_back(int'(nibble));
            end
            for (int b = 0; b < 4; b++) begin
                cmp      = hist1[b];
                hist1[b] = hist0[b];
                hist0[b] = raw[b];
                pend[b]  = 0;
                if (cmp != acc[b]) begin
                    run[b]++;
                    if (run[b] == D) begin
                        acc[b]  = cmp;
                        run[b]  = 0;
                        pend[b] = cmp;
                    end
                end else begin
                    run[b] = 0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            checkOutput("edit_o", edit, word_of(m_digits));
            checkOutput("digit_cnt_o", 32'(digit_cnt), 32'(m_digits.size()));
            checkOutput("full_o", 32'(full), 32'(m_digits.size() == DIGITS));
            checkOutput("data_o", data, m_data);
            checkOutput("valid_o", 32'(valid), 32'(m_valid));
            if (valid === 1'b1) valid_cycles++;
        end
    end

    // btns bits: 0 load, 1 commit, 2 clear, 3 back.
    task automatic applyStimulus(input logic [3:0] btns, input logic [3:0] nib,
                                 input int hold, input int gap);
        @(negedge clk);
        nibble     = nib;
        btn_load   = btns[0];
        btn_commit = btns[1];
        btn_clear  = btns[2];
        btn_back   = btns[3];
        repeat (hold) @(negedge clk);
        btn_load = 0; btn_commit = 0; btn_clear = 0; btn_back = 0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] btns, input logic [3:0] nib);
        applyStimulus(btns, nib, 10, D + 8);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        logic [3:0] seq[8] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h1, 4'h2, 4'h3, 4'h4};
        logic [3:0] mask;
        repeat (3) @(negedge clk);
        rst = 0;
        checkOutput("reset edit_o", edit, 32'd0);
        checkOutput("reset valid_o", 32'(valid), 32'd0);
        checkOutput("reset data_o", data, 32'd0);

        applyStimulus(4'b0001, 4'hA, 3, D + 8);
        checkOutput("short press cnt", 32'(digit_cnt), 32'd0);

        for (int i = 0; i < 8; i++) begin
            press(4'b0001, seq[i]);
            if (i == 0) begin
                checkOutput("first load edit", edit, 32'h0000_000A);
                checkOutput("first load cnt", 32'(digit_cnt), 32'd1);
            end
        end
        checkOutput("full edit", edit, 32'hABCD_1234);
        checkOutput("full flag", 32'(full), 32'd1);
        press(4'b0001, 4'hF);
        checkOutput("ninth load edit", edit, 32'hABCD_1234);

        press(4'b0010, 4'h0);
        checkOutput("commit valid", 32'(valid), 32'd1);
        checkOutput("commit data", data, 32'hABCD_1234);
        checkOutput("commit edit", edit, 32'd0);
        press(4'b0001, 4'h5);
        press(4'b0010, 4'h5);
        checkOutput("hold ignores load", 32'(digit_cnt), 32'd0);
        checkOutput("hold keeps valid", 32'(valid), 32'd1);
        @(negedge clk); ready = 1;
        repeat (2) @(negedge clk);
        checkOutput("handshake valid", 32'(valid), 32'd0);
        checkOutput("handshake data", data, 32'hABCD_1234);
        ready = 0;

        press(4'b0010, 4'h0);
        checkOutput("empty commit", 32'(valid), 32'd0);
        press(4'b0001, 4'h5);
        press(4'b0110, 4'h5);
        checkOutput("clear wins edit", edit, 32'd0);
        checkOutput("clear wins valid", 32'(valid), 32'd0);

        ready = 1;
        press(4'b0001, 4'h7);
        valid_cycles = 0;
        press(4'b0010, 4'h7);
        checkOutput("one-cycle valid", 32'(valid_cycles), 32'd1);
        checkOutput("one-cycle data", data, 32'h0000_0007);
        ready = 0;

`ifdef ENTRY_BACKSPACE_EN
        press(4'b0001, 4'h1);
        press(4'b0001, 4'h2);
        press(4'b0001, 4'h3);
        press(4'b1000, 4'h3);
        checkOutput("back edit", edit, 32'h0000_0012);
        checkOutput("back cnt", 32'(digit_cnt), 32'd2);
        repeat (3) press(4'b1000, 4'h3);
        checkOutput("back to empty", 32'(digit_cnt), 32'd0);
        mask = 4'b1111;
`else
        mask = 4'b0111;
`endif

        press(4'b0001, 4'h9);
        press(4'b0010, 4'h9);
        pulse_reset();
        checkOutput("hold reset valid", 32'(valid), 32'd0);
        checkOutput("hold reset data", data, 32'd0);

        @(negedge clk); btn_load = 1;
        repeat (4) @(negedge clk);
        rst = 1;
        @(negedge clk); rst = 0;
        @(negedge clk); btn_load = 0;
        repeat (D + 8) @(negedge clk);
        checkOutput("mid-debounce reset", 32'(digit_cnt), 32'd0);

        for (int i = 0; i < 250; i++) begin
            ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) pulse_reset();
            applyStimulus(4'($urandom_range(0, 15)) & mask, 4'($urandom_range(0, 15)),
                          $urandom_range(1, 12), $urandom_range(0, 12));
        end
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
